// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared sizing constants and FSM state encoding for the
//                router output controller.
//  Config      : ROUTER_PARITY_EN adds the PARITY state to the encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package router_pkg;

    localparam int NUM_PORTS = 16;
    localparam int DATA_W    = 8;
    localparam int LEN_W     = 6;
    localparam int IDX_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef ROUTER_PARITY_EN
        S_PARITY  = 3'd3,
`endif
        S_DONE    = 3'd4
    } state_t;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_onehot_enc.sv
`default_nettype none
// ============================================================================
//  Module      : router_onehot_enc
//  Description : Combinational grant encoder. Returns the index of the lowest
//                set grant bit (highest priority) and flags grants that have
//                more than one bit set.
//  Ports       : i_grant  [15:0] grant vector
//                o_idx    [3:0]  lowest set index (0 when grant is zero)
//                o_multi         more than one grant bit set
//  Revision    : 1.0  initial release
// ============================================================================
module router_onehot_enc
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_grant,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_multi
);

    logic [NUM_PORTS-1:0] w_grant_m1;

    // Clearing the lowest set bit leaves something only if a second bit is set.
    assign w_grant_m1 = i_grant - {{(NUM_PORTS-1){1'b0}}, 1'b1};
    assign o_multi    = |(i_grant & w_grant_m1);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (i_grant[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule : router_onehot_enc
`default_nettype wire

// File: rtl/router_output_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_output_ctrl
//  Description : Output-port controller of a 16-input router. Locks onto the
//                arbiter's granted input, forwards one packet (header byte
//                carrying payload length N, then N payload bytes) with zero
//                cycle latency, then pulses done for the owner.
//  Config      : ROUTER_PARITY_EN appends an XOR parity byte over header and
//                payload after the payload.
//  Ports       : clk, reset_n          clock, async active-low reset
//                grant[15:0], busy     arbiter owner / busy
//                in_data[127:0]        port i byte at [8i+7:8i]
//                in_valid[15:0]        per-port valid
//                in_ready[15:0]        per-port pop (locked port only)
//                out_data[7:0]         forwarded byte
//                out_valid, out_ready  downstream handshake
//                done[15:0]            end-of-packet pulse on owner's bit
//                err_multi             non-one-hot grant seen at lock
//  Revision    : 1.0  initial release
// ============================================================================
module router_output_ctrl
    import router_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        grant,
    input  logic                        busy,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        err_multi
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_err;

    logic [IDX_W-1:0]      w_enc_idx;
    logic                  w_enc_multi;
    logic [DATA_W-1:0]     w_sel_data;
    logic                  w_sel_valid;
    logic [NUM_PORTS-1:0]  w_own;
    logic                  w_xfer;

`ifdef ROUTER_PARITY_EN
    logic [DATA_W-1:0]     r_par;
`endif

    router_onehot_enc u_enc (
        .i_grant (grant),
        .o_idx   (w_enc_idx),
        .o_multi (w_enc_multi)
    );

    assign w_sel_data  = in_data[{r_idx, 3'b000} +: DATA_W];
    assign w_sel_valid = in_valid[r_idx];
    assign w_own       = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_idx;
    assign w_xfer      = out_valid & out_ready;
    assign err_multi   = r_err;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_data    = '0;
        in_ready    = '0;
        done        = '0;

        case (r_state)
            S_IDLE: begin
                if (busy) begin
                    w_state_nxt = S_HEADER;
                end
            end

            S_HEADER: begin
                out_valid = w_sel_valid;
                out_data  = w_sel_data;
                in_ready  = out_ready ? w_own : '0;
                if (w_xfer) begin
                    if (w_sel_data[LEN_W-1:0] != '0) begin
                        w_state_nxt = S_PAYLOAD;
                    end else begin
`ifdef ROUTER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_DONE;
`endif
                    end
                end
            end

            S_PAYLOAD: begin
                out_valid = w_sel_valid;
                out_data  = w_sel_data;
                in_ready  = out_ready ? w_own : '0;
                if (w_xfer && (r_cnt == LEN_W'(1))) begin
`ifdef ROUTER_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end

`ifdef ROUTER_PARITY_EN
            S_PARITY: begin
                out_valid = 1'b1;
                out_data  = r_par;
                if (out_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif

            S_DONE: begin
                // One blank cycle lets the source drop its stale request
                // before IDLE samples busy again.
                done        = w_own;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Owner index, remaining-length counter, error pulse, parity accumulator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
`ifdef ROUTER_PARITY_EN
            r_par <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (busy) begin
                        r_idx <= w_enc_idx;
                        r_err <= w_enc_multi;
                    end
                end
                S_HEADER: begin
                    if (w_xfer) begin
                        r_cnt <= w_sel_data[LEN_W-1:0];
`ifdef ROUTER_PARITY_EN
                        r_par <= w_sel_data;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - LEN_W'(1);
`ifdef ROUTER_PARITY_EN
                        r_par <= r_par ^ w_sel_data;
`endif
                    end
                end
                S_DONE: begin
                    r_cnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : router_output_ctrl
`default_nettype wire

// File: tb/tb_router_output_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_output_ctrl
//  Description : Directed self-checking bench for router_output_ctrl. Builds
//                with or without ROUTER_PARITY_EN; packet tails check the
//                parity byte only when the feature is compiled in.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_router_output_ctrl;

    logic         clk;
    logic         reset_n;
    logic [15:0]  grant;
    logic         busy;
    logic [127:0] in_data;
    logic [15:0]  in_valid;
    logic [15:0]  in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  done;
    logic         err_multi;

    int checks = 0;
    int errors = 0;

    router_output_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .grant     (grant),
        .busy      (busy),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .err_multi (err_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int p, input logic [7:0] b);
        in_data = '0;
        in_data[p*8 +: 8] = b;
        in_valid = 16'h0001 << p;
    endtask

    task automatic lock(input logic [15:0] g);
        grant = g;
        busy  = 1'b1;
        tick();
        grant = '0;
        busy  = 1'b0;
    endtask

    task automatic xfer_byte(input int p, input logic [7:0] b);
        present(p, b);
        out_ready = 1'b1;
        #1;
        chk("xfer_valid", {31'd0, out_valid}, 32'd1);
        chk("xfer_data", {24'd0, out_data}, {24'd0, b});
        chk("xfer_ready", {16'd0, in_ready}, 32'h1 << p);
        tick();
    endtask

    task automatic finish_pkt(input int p, input logic [7:0] par);
`ifdef ROUTER_PARITY_EN
        in_valid  = '0;
        out_ready = 1'b1;
        #1;
        chk("parity_valid", {31'd0, out_valid}, 32'd1);
        chk("parity_data", {24'd0, out_data}, {24'd0, par});
        chk("parity_in_ready", {16'd0, in_ready}, 32'd0);
        tick();
`else
        if (par == 8'hxx) $display("unused");
`endif
        #1;
        chk("done_pulse", {16'd0, done}, 32'h1 << p);
        chk("done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("done_in_ready", {16'd0, in_ready}, 32'd0);
        tick();
        chk("done_cleared", {16'd0, done}, 32'd0);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b1;
        grant     = '0;
        busy      = 1'b0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", {16'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_done", {16'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err_multi}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Idle with a valid input but no busy: nothing forwarded.
        present(2, 8'h03);
        #1;
        chk("idle_no_fwd", {31'd0, out_valid}, 32'd0);
        chk("idle_no_ready", {16'd0, in_ready}, 32'd0);
        tick();

        // Basic packet on port 2: 03 AA BB CC.
        lock(16'h0004);
        chk("single_err", {31'd0, err_multi}, 32'd0);
        xfer_byte(2, 8'h03);
        xfer_byte(2, 8'hAA);
        xfer_byte(2, 8'hBB);
        xfer_byte(2, 8'hCC);
        finish_pkt(2, 8'hDE);

        // Zero-length packet on port 0.
        lock(16'h0001);
        xfer_byte(0, 8'h00);
        finish_pkt(0, 8'h00);

        // 5-byte payload on port 7 with alternating back-pressure and a bubble.
        lock(16'h0080);
        xfer_byte(7, 8'h05);
        in_valid = '0;
        #1;
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            out_ready = 1'b0;
            present(7, 8'(k * 8'h11));
            #1;
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {24'd0, out_data}, 32'(k * 8'h11));
            chk("stall_in_ready", {16'd0, in_ready}, 32'd0);
            tick();
            xfer_byte(7, 8'(k * 8'h11));
        end
        finish_pkt(7, 8'h14);

        // Multi-hot grant: lowest index wins, err pulses once.
        grant = 16'h0030;
        busy  = 1'b1;
        #1;
        chk("err_before_lock", {31'd0, err_multi}, 32'd0);
        tick();
        grant = '0;
        busy  = 1'b0;
        chk("err_pulse", {31'd0, err_multi}, 32'd1);
        in_data = '0;
        in_data[4*8 +: 8] = 8'h00;
        in_data[5*8 +: 8] = 8'h77;
        in_valid = 16'h0030;
        #1;
        chk("multi_in_ready", {16'd0, in_ready}, 32'h0010);
        chk("multi_data", {24'd0, out_data}, 32'h00);
        tick();
        chk("err_one_cycle", {31'd0, err_multi}, 32'd0);
        finish_pkt(4, 8'h00);

        // Reset mid-packet after 2 of 4 payload bytes.
        lock(16'h0008);
        xfer_byte(3, 8'h04);
        xfer_byte(3, 8'h10);
        xfer_byte(3, 8'h20);
        present(3, 8'h30);
        #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {16'd0, in_ready}, 32'd0);
        chk("midrst_out_data", {24'd0, out_data}, 32'd0);
        chk("midrst_done", {16'd0, done}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
        tick();
        chk("post_rst_idle2", {16'd0, in_ready}, 32'd0);
        lock(16'h0200);
        xfer_byte(9, 8'h01);
        xfer_byte(9, 8'h5A);
        finish_pkt(9, 8'h5B);

`ifdef ROUTER_PARITY_EN
        // Parity byte with a stall before it is accepted.
        lock(16'h0002);
        xfer_byte(1, 8'h02);
        xfer_byte(1, 8'h0F);
        xfer_byte(1, 8'hF0);
        out_ready = 1'b0;
        in_valid  = '0;
        #1;
        chk("par_stall_valid", {31'd0, out_valid}, 32'd1);
        chk("par_stall_data", {24'd0, out_data}, 32'hFD);
        tick();
        chk("par_hold_data", {24'd0, out_data}, 32'hFD);
        finish_pkt(1, 8'hFD);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_router_output_ctrl
`default_nettype wire
